// File: rtl/piradip_register_arbiter.sv
// Round-robin arbiter sharing one register bus among NUM_REQ requesters; one access per 3 cycles.
// Define PIRADIP_REGARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins) instead of round-robin.
module piradip_register_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int DATA_WIDTH         = 32,
    parameter int REGISTER_ADDR_BITS = 8,
    localparam int STRB_WIDTH        = DATA_WIDTH / 8
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0]                     req_write,
    input  logic [NUM_REQ*REGISTER_ADDR_BITS-1:0]  req_regno,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]          req_wstrb,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [DATA_WIDTH-1:0]                  rsp_rdata,
    output logic                                   busy,
    output logic                                   wren,
    output logic                                   rden,
    output logic [REGISTER_ADDR_BITS-1:0]          wreg_no,
    output logic [REGISTER_ADDR_BITS-1:0]          rreg_no,
    output logic [DATA_WIDTH-1:0]                  wreg_data,
    output logic [STRB_WIDTH-1:0]                  wstrb,
    input  logic [DATA_WIDTH-1:0]                  rreg_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [IDX_W-1:0]                r_gnt;
    logic                            r_write;
    logic [REGISTER_ADDR_BITS-1:0]   r_regno;
    logic [DATA_WIDTH-1:0]           r_wdata;
    logic [STRB_WIDTH-1:0]           r_wstrb;
    logic [DATA_WIDTH-1:0]           r_rdata;
    logic                            w_any;
    logic [IDX_W-1:0]                w_gnt;

`ifdef PIRADIP_REGARB_FIXED_PRIORITY_EN
    always_comb begin
        w_any = |req_valid;
        w_gnt = '0;
        // Scan downward so the lowest asserted index is the last assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) w_gnt = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0]                r_ptr;
    logic                            w_found;
    int                              w_idx;

    always_comb begin
        w_any   = |req_valid;
        w_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= IDX_W'((int'(w_gnt) + 1) % NUM_REQ);
        end
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        wren      = 1'b0;
        rden      = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (w_any) req_ready[w_gnt] = 1'b1;
            S_ISSUE: begin
                wren = r_write;
                rden = !r_write;
            end
            S_RESP:  rsp_valid[r_gnt] = 1'b1;
            default: ;
        endcase
    end

    // The winner's payload is captured at accept; bus outputs hold it until the next accept.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_gnt   <= '0;
            r_write <= 1'b0;
            r_regno <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_gnt   <= w_gnt;
                r_write <= req_write[w_gnt];
                r_regno <= req_regno[w_gnt*REGISTER_ADDR_BITS +: REGISTER_ADDR_BITS];
                r_wdata <= req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                r_wstrb <= req_wstrb[w_gnt*STRB_WIDTH +: STRB_WIDTH];
            end
            if (r_state == S_ISSUE && !r_write) begin
                r_rdata <= rreg_data;
            end
        end
    end

    assign wreg_no   = r_regno;
    assign rreg_no   = r_regno;
    assign wreg_data = r_wdata;
    assign wstrb     = r_wstrb;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_piradip_register_arbiter.sv
// Randomized bench for piradip_register_arbiter against a timeline-based transaction model.
module tb_piradip_register_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 4;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_regno;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              busy;
    logic              wren;
    logic              rden;
    logic [AW-1:0]     wreg_no;
    logic [AW-1:0]     rreg_no;
    logic [DW-1:0]     wreg_data;
    logic [SW-1:0]     wstrb;
    logic [DW-1:0]     rreg_data;

    piradip_register_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .REGISTER_ADDR_BITS(AW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_write(req_write), .req_regno(req_regno),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .wren(wren), .rden(rden), .wreg_no(wreg_no), .rreg_no(rreg_no),
        .wreg_data(wreg_data), .wstrb(wstrb), .rreg_data(rreg_data)
    );

    always #5 aclk = ~aclk;

    function automatic logic [DW-1:0] client_data(input logic [AW-1:0] r);
        return (r == 8'h10) ? 32'h1234_5678 : {r, ~r, r ^ 8'h5A, 8'hC3};
    endfunction

    assign rreg_data = client_data(rreg_no);

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: an access accepted at cycle A strobes at A+1, responds at A+2, frees the bus at A+3.
    int            cyc;
    int            m_ptr;
    int            m_acc;
    int            m_g;
    logic          m_w;
    logic [AW-1:0] m_regno;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [DW-1:0] m_rdata;
    int            q_gnt[$];

    task automatic model_reset();
        m_ptr   = 0;
        m_acc   = -100;
        m_g     = 0;
        m_w     = 1'b0;
        m_regno = '0;
        m_wdata = '0;
        m_wstrb = '0;
        m_rdata = '0;
    endtask

    function automatic int pick();
`ifdef PIRADIP_REGARB_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (req_valid[i]) return i;
`else
        for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] r,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_write[i]          = w;
        req_regno[i*AW +: AW] = r;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
        req_valid[i]          = 1'b1;
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, advances model past the next edge.
    task automatic step(input bit drop);
        int       g;
        bit       strobe;
        bit       resp;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rsp;
        #4;
        strobe = (cyc == m_acc + 1);
        resp   = (cyc == m_acc + 2);
        g      = (cyc >= m_acc + 3) ? pick() : -1;
        e_rdy  = '0;
        e_rsp  = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        if (resp) e_rsp[m_g] = 1'b1;
        check("req_ready", req_ready, e_rdy);
        check("rsp_valid", rsp_valid, e_rsp);
        check("wren", wren, strobe && m_w);
        check("rden", rden, strobe && !m_w);
        check("busy", busy, strobe || resp);
        check("wreg_no", wreg_no, m_regno);
        check("rreg_no", rreg_no, m_regno);
        check("wreg_data", wreg_data, m_wdata);
        check("wstrb", wstrb, m_wstrb);
        check("rsp_rdata", rsp_rdata, m_rdata);
        if (strobe && !m_w) m_rdata = client_data(m_regno);
        if (g >= 0) begin
            m_acc   = cyc;
            m_g     = g;
            m_w     = req_write[g];
            m_regno = req_regno[g*AW +: AW];
            m_wdata = req_wdata[g*DW +: DW];
            m_wstrb = req_wstrb[g*SW +: SW];
            m_ptr   = (g + 1) % N;
            q_gnt.push_back(g);
        end
        @(posedge aclk);
        #1;
        cyc++;
        if (g >= 0 && drop) req_valid[g] = 1'b0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        #2;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
        cyc++;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (3) step(1'b1);
    endtask

    initial begin
        logic [N-1:0] all_on;
        int exp_first;
        int exp_second;
        all_on    = '1;
        areset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_regno = '0;
        req_wdata = '0;
        req_wstrb = '0;
        cyc       = 0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {wren, rden}, 0);
        check("rst_wreg_data", wreg_data, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        areset = 1'b0;

        // Single write from requester 2.
        set_req(2, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF);
        repeat (3) step(1'b1);

        // Read of regno 0x10 by requester 0.
        set_req(0, 1'b0, 8'h10, 32'h0BAD_F00D, 4'h3);
        repeat (3) step(1'b1);
        check("read_rdata", rsp_rdata, 32'h1234_5678);

        // Contention: all requesters hold request continuously from reset.
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, 1'($urandom_range(1)), 8'($urandom), $urandom, 4'($urandom));
        q_gnt.delete();
        repeat (13) step(1'b0);
        req_valid = '0;
        repeat (3) step(1'b1);
        check("cont_count", q_gnt.size(), 5);
        for (int k = 0; k < 5; k++) begin
`ifdef PIRADIP_REGARB_FIXED_PRIORITY_EN
            check("cont_order", (q_gnt.size() > k) ? q_gnt[k] : 99, 0);
`else
            check("cont_order", (q_gnt.size() > k) ? q_gnt[k] : 99, k % N);
`endif
        end
        check("all_on_reached", all_on, 4'hF);

        // Wrap: requester 2 moves ptr to 3, then 1 and 3 request together.
        set_req(2, 1'b1, 8'h22, 32'h2222_2222, 4'h1);
        repeat (3) step(1'b1);
        q_gnt.delete();
        set_req(1, 1'b0, 8'h11, 32'h1111_1111, 4'h2);
        set_req(3, 1'b1, 8'h33, 32'h3333_3333, 4'h4);
        repeat (6) step(1'b1);
`ifdef PIRADIP_REGARB_FIXED_PRIORITY_EN
        exp_first = 1; exp_second = 3;
`else
        exp_first = 3; exp_second = 1;
`endif
        check("wrap_count", q_gnt.size(), 2);
        check("wrap_first", (q_gnt.size() > 0) ? q_gnt[0] : 99, exp_first);
        check("wrap_second", (q_gnt.size() > 1) ? q_gnt[1] : 99, exp_second);

        // Reset asserted during the wren cycle.
        set_req(1, 1'b1, 8'h44, 32'hCAFE_0001, 4'hF);
        step(1'b1);
        #2;
        check("pre_rst_wren", wren, 1);
        areset = 1'b1;
        #1;
        check("mid_rst_wren", wren, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wreg_no", wreg_no, 0);
        @(posedge aclk);
        #1;
        check("rst_hold_rsp", rsp_valid, 0);
        areset = 1'b0;
        model_reset();
        cyc++;
        q_gnt.delete();
        set_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
        set_req(3, 1'b1, 8'h66, 32'h6666_6666, 4'h8);
        repeat (6) step(1'b1);
        check("post_rst_winner", (q_gnt.size() > 0) ? q_gnt[0] : 99, 0);
        drain();

        // Randomized traffic with withdrawals.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(3) == 0)
                        set_req(i, 1'($urandom_range(1)), 8'($urandom), $urandom, 4'($urandom));
                end else if ($urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step(1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
